// File: rtl/mem_elem_pkg.sv
// Shared types for the element-memory arbiter.
// Owner tags for read returns and the arbiter FSM states.
package mem_elem_pkg;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_CFG,
    TAG_EJEC,
    TAG_UI
  } tag_e;

  typedef enum logic {
    ST_ARB,
    ST_CFG_LOCK
  } state_e;

endpackage

// File: rtl/mem_elem_rdtag.sv
// Read-return owner-tag shift pipeline, RD_LAT stages deep.
// Ports: clk, rst, tag_in (issued read owner), tag_out (returning owner).
module mem_elem_rdtag
  import mem_elem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_e tag_in,
  output tag_e tag_out
);

  tag_e pipe [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_elem_arbiter.sv
// Three-way element-memory arbiter: cfg > ejec > ui with ui anti-starvation
// and a cfg bus lock. Ports: cfg/ejec/ui request ports, memory port, rdata.
module mem_elem_arbiter
  import mem_elem_pkg::*;
#(
  parameter int DATA_W     = 800,
  parameter int ADDR_W     = 7,
  parameter int DEPTH      = 60,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_req,
  input  logic              cfg_we,
  input  logic              cfg_lock,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_ack,
  output logic              cfg_rvalid,
  output logic              cfg_err,
  input  logic              ejec_req,
  input  logic [ADDR_W-1:0] ejec_addr,
  output logic              ejec_ack,
  output logic              ejec_rvalid,
  output logic              ejec_err,
  input  logic              ui_req,
  input  logic [ADDR_W-1:0] ui_addr,
  output logic              ui_ack,
  output logic              ui_rvalid,
  output logic              ui_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy_cfg
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e            state_q, state_d;
  tag_e              gnt, tag_in, tag_out;
  logic [SW-1:0]     starve_q;
  logic [ADDR_W-1:0] addr_sel;
  logic              ui_wins, bad, any_rv;
  logic [DATA_W-1:0] rdata_q;

  assign ui_wins = ui_req && (starve_q == SW'(STARVE_MAX));

  // Grants are suppressed during reset so every output reads 0.
  always_comb begin
    gnt     = TAG_NONE;
    state_d = state_q;
    if (!rst) begin
      if (state_q == ST_CFG_LOCK) begin
        if (cfg_req) gnt = TAG_CFG;
        if (!cfg_lock) state_d = ST_ARB;
      end else begin
        if (cfg_req) gnt = TAG_CFG;
        else if (ejec_req && !ui_wins) gnt = TAG_EJEC;
        else if (ui_req) gnt = TAG_UI;
        if (gnt == TAG_CFG && cfg_lock) state_d = ST_CFG_LOCK;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    unique case (gnt)
      TAG_CFG:  addr_sel = cfg_addr;
      TAG_EJEC: addr_sel = ejec_addr;
      TAG_UI:   addr_sel = ui_addr;
      default:  addr_sel = '0;
    endcase
  end

  assign bad      = (gnt != TAG_NONE) && (32'(addr_sel) >= DEPTH);
  assign mem_en   = (gnt != TAG_NONE) && !bad;
  assign mem_we   = mem_en && (gnt == TAG_CFG) && cfg_we;
  assign mem_addr = mem_en ? addr_sel : '0;
  assign mem_din  = mem_we ? cfg_wdata : '0;

  assign cfg_ack  = (gnt == TAG_CFG);
  assign ejec_ack = (gnt == TAG_EJEC);
  assign ui_ack   = (gnt == TAG_UI);
  assign cfg_err  = cfg_ack && bad;
  assign ejec_err = ejec_ack && bad;
  assign ui_err   = ui_ack && bad;
  assign busy_cfg = (state_q == ST_CFG_LOCK);

  assign tag_in = (mem_en && !mem_we) ? gnt : TAG_NONE;

  mem_elem_rdtag #(.RD_LAT(RD_LAT)) u_rdtag (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign cfg_rvalid  = (tag_out == TAG_CFG);
  assign ejec_rvalid = (tag_out == TAG_EJEC);
  assign ui_rvalid   = (tag_out == TAG_UI);
  assign any_rv      = (tag_out != TAG_NONE);

  // Pass memory data through on a return, otherwise hold the last word.
  assign rdata = any_rv ? mem_dout : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ARB;
      starve_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (any_rv) rdata_q <= mem_dout;
      if (!ui_req || gnt == TAG_UI) starve_q <= '0;
      else if (gnt == TAG_EJEC && starve_q != SW'(STARVE_MAX))
        starve_q <= starve_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_elem_arbiter.sv
// Self-checking bench for mem_elem_arbiter: vector table, scoreboard of
// read returns, and sequences for lock, starvation and reset corners.
module tb_mem_elem_arbiter;

  localparam int DW = 800;
  localparam int AW = 7;

  logic          clk = 0;
  logic          rst = 1;
  always #5 clk = ~clk;

  logic          cfg_req = 0, cfg_we = 0, cfg_lock = 0;
  logic [AW-1:0] cfg_addr = 0;
  logic [DW-1:0] cfg_wdata = 0;
  logic          ejec_req = 0, ui_req = 0;
  logic [AW-1:0] ejec_addr = 0, ui_addr = 0;
  logic          cfg_ack, cfg_rvalid, cfg_err;
  logic          ejec_ack, ejec_rvalid, ejec_err;
  logic          ui_ack, ui_rvalid, ui_err;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic          mem_en, mem_we, busy_cfg;
  logic [AW-1:0] mem_addr;

  mem_elem_arbiter dut (
    .clk(clk), .rst(rst),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_lock(cfg_lock),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(cfg_ack), .cfg_rvalid(cfg_rvalid), .cfg_err(cfg_err),
    .ejec_req(ejec_req), .ejec_addr(ejec_addr),
    .ejec_ack(ejec_ack), .ejec_rvalid(ejec_rvalid), .ejec_err(ejec_err),
    .ui_req(ui_req), .ui_addr(ui_addr),
    .ui_ack(ui_ack), .ui_rvalid(ui_rvalid), .ui_err(ui_err),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy_cfg(busy_cfg)
  );

  // Second instance with RD_LAT=3 for the reset-in-flight corner.
  logic          b_zero = 0;
  logic [AW-1:0] b_zaddr = 0;
  logic [DW-1:0] b_zdata = 0;
  logic [DW-1:0] b_dout = '1;
  logic          b_ejec_req = 0;
  logic [AW-1:0] b_ejec_addr = 0;
  logic          b_cfg_ack, b_cfg_rvalid, b_cfg_err;
  logic          b_ejec_ack, b_ejec_rvalid, b_ejec_err;
  logic          b_ui_ack, b_ui_rvalid, b_ui_err;
  logic [DW-1:0] b_rdata, b_mem_din;
  logic          b_mem_en, b_mem_we, b_busy;
  logic [AW-1:0] b_mem_addr;

  mem_elem_arbiter #(.RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .cfg_req(b_zero), .cfg_we(b_zero), .cfg_lock(b_zero),
    .cfg_addr(b_zaddr), .cfg_wdata(b_zdata),
    .cfg_ack(b_cfg_ack), .cfg_rvalid(b_cfg_rvalid), .cfg_err(b_cfg_err),
    .ejec_req(b_ejec_req), .ejec_addr(b_ejec_addr),
    .ejec_ack(b_ejec_ack), .ejec_rvalid(b_ejec_rvalid),
    .ejec_err(b_ejec_err),
    .ui_req(b_zero), .ui_addr(b_zaddr),
    .ui_ack(b_ui_ack), .ui_rvalid(b_ui_rvalid), .ui_err(b_ui_err),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_dout),
    .busy_cfg(b_busy)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] word(int a);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(a);
    return {25{w}};
  endfunction

  // Synchronous RAM model, one-cycle read latency.
  logic [DW-1:0] ram [128];
  logic [DW-1:0] exp_mem [128];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]    own;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sbq [$];

  // Scoreboard: pop/compare returns first, then record this cycle's issues.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_rvalid || ejec_rvalid || ui_rvalid) begin
        sb_t e;
        logic [1:0] own;
        own = {ejec_rvalid | ui_rvalid, cfg_rvalid | ui_rvalid};
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: got owner %0d expected none",
                   own);
        end else begin
          e = sbq.pop_front();
          if (own !== e.own || rdata !== e.data
              || (32'(cfg_rvalid) + 32'(ejec_rvalid) + 32'(ui_rvalid)) != 1)
          begin
            errors++;
            $display("FAIL rvalid_return: got owner %0d data %h expected owner %0d data %h",
                     own, rdata[31:0], e.own, e.data[31:0]);
          end
        end
      end
      if (cfg_ack && !cfg_err) begin
        if (cfg_we) exp_mem[cfg_addr] = cfg_wdata;
        else sbq.push_back({2'd1, exp_mem[cfg_addr]});
      end
      if (ejec_ack && !ejec_err) sbq.push_back({2'd2, exp_mem[ejec_addr]});
      if (ui_ack && !ui_err) sbq.push_back({2'd3, exp_mem[ui_addr]});
    end
  end

  typedef struct {
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wd;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic          u_req;
    logic [AW-1:0] u_addr;
    logic [2:0]    x_ack, x_err;
    logic          x_en, x_we;
    logic [AW-1:0] x_addr;
    logic [31:0]   x_din;
  } vec_t;

  vec_t vt [13];

  task automatic idle();
    cfg_req = 0; cfg_we = 0; cfg_lock = 0; cfg_addr = 0; cfg_wdata = 0;
    ejec_req = 0; ejec_addr = 0; ui_req = 0; ui_addr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i] = word(i);
      exp_mem[i] = word(i);
    end
    //        cr we ca  wd            er ea  ur ua  ack    err    en we addr din
    vt[0]  = '{0, 0, 0, 0,            0, 0,  0, 0,  3'b000, 3'b000, 0, 0, 0,  0};
    vt[1]  = '{0, 0, 0, 0,            1, 5,  0, 0,  3'b010, 3'b000, 1, 0, 5,  0};
    vt[2]  = '{0, 0, 0, 0,            0, 0,  1, 7,  3'b001, 3'b000, 1, 0, 7,  0};
    vt[3]  = '{1, 0, 3, 0,            0, 0,  0, 0,  3'b100, 3'b000, 1, 0, 3,  0};
    vt[4]  = '{1, 1, 10, 32'h12345678, 0, 0, 0, 0,  3'b100, 3'b000, 1, 1, 10, 32'h12345678};
    vt[5]  = '{1, 0, 20, 0,           1, 21, 1, 22, 3'b100, 3'b000, 1, 0, 20, 0};
    vt[6]  = '{0, 0, 0, 0,            1, 30, 1, 31, 3'b010, 3'b000, 1, 0, 30, 0};
    vt[7]  = '{0, 0, 0, 0,            0, 0,  1, 60, 3'b001, 3'b001, 0, 0, 0,  0};
    vt[8]  = '{0, 0, 0, 0,            1, 127, 0, 0, 3'b010, 3'b010, 0, 0, 0,  0};
    vt[9]  = '{1, 1, 59, 32'h0000CAFE, 0, 0, 0, 0,  3'b100, 3'b000, 1, 1, 59, 32'h0000CAFE};
    vt[10] = '{1, 1, 60, 32'h0BADF00D, 0, 0, 0, 0,  3'b100, 3'b100, 0, 0, 0,  0};
    vt[11] = '{0, 0, 0, 0,            0, 0,  1, 10, 3'b001, 3'b000, 1, 0, 10, 0};
    vt[12] = '{0, 0, 0, 0,            1, 59, 0, 0,  3'b010, 3'b000, 1, 0, 59, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acks", {61'd0, cfg_ack, ejec_ack, ui_ack}, 0);
    chk("rst_mem_en", {63'd0, mem_en | mem_we}, 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_rdata", rdata[63:0], 0);
    chk("rst_busy", {63'd0, busy_cfg}, 0);
    @(posedge clk); #1 rst = 0;

    foreach (vt[i]) begin
      @(posedge clk); #1;
      cfg_req = vt[i].c_req; cfg_we = vt[i].c_we; cfg_addr = vt[i].c_addr;
      cfg_wdata = {25{vt[i].c_wd}};
      ejec_req = vt[i].e_req; ejec_addr = vt[i].e_addr;
      ui_req = vt[i].u_req; ui_addr = vt[i].u_addr;
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), 64'({cfg_ack, ejec_ack, ui_ack}),
          64'(vt[i].x_ack));
      chk($sformatf("v%0d_err", i), 64'({cfg_err, ejec_err, ui_err}),
          64'(vt[i].x_err));
      chk($sformatf("v%0d_en_we", i), 64'({mem_en, mem_we}),
          64'({vt[i].x_en, vt[i].x_we}));
      chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(vt[i].x_addr));
      chk($sformatf("v%0d_din", i), mem_din[63:0], {2{vt[i].x_din}});
      @(posedge clk); #1 idle();
    end

    // Single ejec read: ack and address now, data one cycle later.
    @(posedge clk); #1 ejec_req = 1; ejec_addr = 5;
    @(negedge clk);
    chk("ej5_ack", 64'({ejec_ack, mem_en}), 64'b11);
    chk("ej5_addr", 64'(mem_addr), 5);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("ej5_rvalid", 64'(ejec_rvalid), 1);
    chk("ej5_rdata", rdata[63:0], word(5) >> 0);

    // cfg and ejec together: cfg first, ejec next.
    @(posedge clk); #1;
    cfg_req = 1; cfg_addr = 2; ejec_req = 1; ejec_addr = 4;
    @(negedge clk);
    chk("both_c1", 64'({cfg_ack, ejec_ack}), 64'b10);
    @(posedge clk); #1 cfg_req = 0;
    @(negedge clk);
    chk("both_c2", 64'({cfg_ack, ejec_ack}), 64'b01);
    @(posedge clk); #1 idle();

    // cfg lock held ten cycles blocks ejec.
    @(posedge clk); #1;
    cfg_req = 1; cfg_lock = 1; cfg_addr = 1; ejec_req = 1; ejec_addr = 9;
    @(negedge clk);
    chk("lock_grant", 64'({cfg_ack, ejec_ack, busy_cfg}), 64'b100);
    @(posedge clk); #1 cfg_req = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("lock_hold%0d", k), 64'({ejec_ack, busy_cfg}), 64'b01);
      @(posedge clk); #1;
    end
    cfg_lock = 0;
    @(negedge clk);
    chk("lock_release", 64'({ejec_ack, busy_cfg}), 64'b01);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lock_after", 64'({ejec_ack, busy_cfg}), 64'b10);
    @(posedge clk); #1 idle();

    // ejec and ui held: eight ejec grants then one ui, repeating.
    @(posedge clk); #1;
    ejec_req = 1; ejec_addr = 11; ui_req = 1; ui_addr = 12;
    for (int k = 0; k < 27; k++) begin
      logic want_ui;
      want_ui = (k % 9) == 8;
      @(negedge clk);
      chk($sformatf("starve%0d", k), 64'({ejec_ack, ui_ack}),
          want_ui ? 64'b01 : 64'b10);
      @(posedge clk); #1;
    end
    idle();

    // Back-to-back mixed owners return in issue order.
    @(posedge clk); #1 cfg_req = 1; cfg_addr = 13;
    @(posedge clk); #1 cfg_req = 0; ejec_req = 1; ejec_addr = 14;
    @(posedge clk); #1 ejec_req = 0; ui_req = 1; ui_addr = 15;
    @(posedge clk); #1 idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 0);

    // RD_LAT=3 read in flight when reset hits.
    @(posedge clk); #1 b_ejec_req = 1; b_ejec_addr = 5;
    @(negedge clk);
    chk("b_grant", 64'({b_ejec_ack, b_mem_en}), 64'b11);
    @(posedge clk); #1 rst = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("b_rst_ctl%0d", k),
          64'({b_cfg_ack, b_ejec_ack, b_ui_ack, b_cfg_err, b_ejec_err,
               b_ui_err, b_cfg_rvalid, b_ejec_rvalid, b_ui_rvalid,
               b_mem_en, b_mem_we, b_busy}), 0);
      chk($sformatf("b_rst_bus%0d", k),
          b_rdata[63:0] | b_mem_din[63:0] | 64'(b_mem_addr), 0);
      @(posedge clk); #1;
    end
    rst = 0; b_ejec_req = 0;
    sbq.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("b_no_rvalid%0d", k), 64'(b_ejec_rvalid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
